// File: rtl/spi_byte_master_if.sv
// Byte handshake between the command processor and the SPI byte engine.
// The master side issues bytes and the slave side (the engine) returns received bytes.
interface spi_byte_master_if;
  logic [7:0] i_tx_byte;
  logic       i_tx_dv;
  logic       o_tx_ready;
  logic [7:0] o_rx_byte;
  logic       o_rx_dv;

  modport master (
    output i_tx_byte,
    output i_tx_dv,
    input  o_tx_ready,
    input  o_rx_byte,
    input  o_rx_dv
  );

  modport slave (
    input  i_tx_byte,
    input  i_tx_dv,
    output o_tx_ready,
    output o_rx_byte,
    output o_rx_dv
  );
endinterface

// File: rtl/spi_byte_master.sv
// SPI master engine: one byte out on MOSI (MSB first) and one byte in from MISO per request.
// Chip select is owned by the command processor; this block only runs SCLK/MOSI/MISO.
module spi_byte_master #(
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  spi_byte_master_if.slave     host,
  output logic                 o_spi_clk,
  output logic                 o_spi_mosi,
  input  logic                 i_spi_miso
);

  localparam bit CPOL = ((SPI_MODE / 2) % 2) == 1;
  localparam bit CPHA = (SPI_MODE % 2) == 1;
  localparam int HW   = $clog2(CLKS_PER_HALF_BIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_reg;
  state_t        state_next;
  logic [4:0]    edge_cnt_reg;
  logic [HW-1:0] half_cnt_reg;
  logic          sclk_reg;
  logic          mosi_reg;
  logic [7:0]    tx_sr_reg;
  logic [7:0]    rx_sr_reg;
  logic [7:0]    rx_byte_reg;

  logic accept;
  logic last_half;
  logic edge_tick;
  logic lead_edge;
  logic sample_edge;
  logic shift_edge;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // DONE also accepts a request so back-to-back bytes need no idle cycle.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (host.i_tx_dv) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (edge_cnt_reg == 5'd0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (host.i_tx_dv) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // edge_cnt counts down 16..1; an even remaining count marks an odd (leading) edge.
  assign last_half   = (half_cnt_reg == HW'(CLKS_PER_HALF_BIT - 1));
  assign edge_tick   = (state_reg == SHIFT) && (edge_cnt_reg != 5'd0) && last_half;
  assign lead_edge   = ~edge_cnt_reg[0];
  assign sample_edge = CPHA ? ~lead_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : (~lead_edge && (edge_cnt_reg != 5'd1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      edge_cnt_reg <= 5'd0;
      half_cnt_reg <= '0;
      sclk_reg     <= CPOL;
      mosi_reg     <= 1'b0;
      tx_sr_reg    <= 8'h00;
      rx_sr_reg    <= 8'h00;
      rx_byte_reg  <= 8'h00;
    end else begin
      if (accept) begin
        edge_cnt_reg <= 5'd16;
        half_cnt_reg <= '0;
        if (CPHA) begin
          tx_sr_reg <= host.i_tx_byte;
        end else begin
          mosi_reg  <= host.i_tx_byte[7];
          tx_sr_reg <= {host.i_tx_byte[6:0], 1'b0};
        end
      end else if ((state_reg == SHIFT) && (edge_cnt_reg != 5'd0)) begin
        half_cnt_reg <= last_half ? '0 : half_cnt_reg + HW'(1);
        if (edge_tick) begin
          sclk_reg     <= ~sclk_reg;
          edge_cnt_reg <= edge_cnt_reg - 5'd1;
          if (sample_edge) begin
            rx_sr_reg <= {rx_sr_reg[6:0], i_spi_miso};
          end
          if (shift_edge) begin
            mosi_reg  <= tx_sr_reg[7];
            tx_sr_reg <= {tx_sr_reg[6:0], 1'b0};
          end
        end
      end else begin
        half_cnt_reg <= '0;
      end

      // Publish the byte as DONE is entered; it then holds until the next completion.
      if ((state_reg == SHIFT) && (edge_cnt_reg == 5'd0)) begin
        rx_byte_reg <= rx_sr_reg;
      end
    end
  end

  assign host.o_tx_ready = (state_reg != SHIFT);
  assign host.o_rx_dv    = (state_reg == DONE);
  assign host.o_rx_byte  = rx_byte_reg;
  assign o_spi_clk       = sclk_reg;
  assign o_spi_mosi      = mosi_reg;

endmodule

// File: tb/tb_spi_byte_master.sv
// Bench for spi_byte_master: three instances (modes 0, 3, 1) with loopback,
// a behavioural SPI slave, or a constant MISO as selectable data sources.
module tb_spi_byte_master;

  localparam int N = 3;

  function automatic int mode_of(input int i);
    return (i == 0) ? 0 : (i == 1) ? 3 : 1;
  endfunction
  function automatic int chb_of(input int i);
    return (i == 1) ? 4 : 2;
  endfunction
  function automatic logic cpol_of(input int i);
    return ((mode_of(i) / 2) % 2) == 1;
  endfunction

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [7:0] tx_byte_a [N];
  logic       tx_dv_a   [N];
  int         miso_src  [N];
  logic       miso_const[N];
  logic [7:0] slv_ret   [N];
  int         arm_req   [N];

  logic       ready_w  [N];
  logic       rx_dv_w  [N];
  logic [7:0] rx_byte_w[N];
  logic       sclk_w   [N];
  logic       mosi_w   [N];
  logic [7:0] slv_rx_w [N];
  int         rises_w  [N];
  int         toggles_w[N];
  int         dvs_w    [N];
  int         viol_w   [N];

  int tests = 0;
  int fails = 0;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_dut
      localparam int MD     = mode_of(gi);
      localparam int CH     = chb_of(gi);
      localparam bit CPOL_L = ((MD / 2) % 2) == 1;
      localparam bit CPHA_L = (MD % 2) == 1;

      spi_byte_master_if u_if ();
      logic sclk_l;
      logic mosi_l;
      logic miso_l;

      // Behavioural SPI slave: samples MOSI on its sampling edges, drives MISO on the others.
      logic [7:0] s_tx   = 8'h00;
      logic [7:0] s_rx   = 8'h00;
      logic       s_miso = 1'b0;
      logic       s_prev = 1'b0;
      int         s_seen = 0;

      // Cycle monitor, sampled on the falling clk edge.
      int   rises   = 0;
      int   toggles = 0;
      int   dvs     = 0;
      int   viol    = 0;
      logic m_sclk  = 1'b0;
      logic m_mosi  = 1'b0;

      assign u_if.i_tx_byte = tx_byte_a[gi];
      assign u_if.i_tx_dv   = tx_dv_a[gi];
      assign ready_w[gi]    = u_if.o_tx_ready;
      assign rx_dv_w[gi]    = u_if.o_rx_dv;
      assign rx_byte_w[gi]  = u_if.o_rx_byte;
      assign sclk_w[gi]     = sclk_l;
      assign mosi_w[gi]     = mosi_l;
      assign slv_rx_w[gi]   = s_rx;
      assign rises_w[gi]    = rises;
      assign toggles_w[gi]  = toggles;
      assign dvs_w[gi]      = dvs;
      assign viol_w[gi]     = viol;
      assign miso_l = (miso_src[gi] == 0) ? mosi_l :
                      (miso_src[gi] == 1) ? s_miso : miso_const[gi];

      spi_byte_master #(
        .SPI_MODE          (MD),
        .CLKS_PER_HALF_BIT (CH)
      ) u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .host       (u_if.slave),
        .o_spi_clk  (sclk_l),
        .o_spi_mosi (mosi_l),
        .i_spi_miso (miso_l)
      );

      always @(arm_req[gi] or sclk_l) begin
        if (arm_req[gi] != s_seen) begin
          s_seen = arm_req[gi];
          s_tx   = slv_ret[gi];
          s_rx   = 8'h00;
          s_prev = sclk_l;
          if (!CPHA_L) begin
            s_miso = s_tx[7];
            s_tx   = {s_tx[6:0], 1'b0};
          end
        end else if (sclk_l !== s_prev) begin
          s_prev = sclk_l;
          if ((sclk_l != CPOL_L) == !CPHA_L) begin
            s_rx = {s_rx[6:0], mosi_l};
          end else begin
            s_miso = s_tx[7];
            s_tx   = {s_tx[6:0], 1'b0};
          end
        end
      end

      always @(negedge clk) begin
        if (m_sclk === 1'b0 && sclk_l === 1'b1) begin
          rises++;
          if (mosi_l !== m_mosi) viol++;
        end
        if (sclk_l !== m_sclk) toggles++;
        if (u_if.o_rx_dv === 1'b1) dvs++;
        m_sclk = sclk_l;
        m_mosi = mosi_l;
      end
    end
  endgenerate

  // Called at a falling edge: request is seen by the next rising edge, then withdrawn.
  task automatic start_xfer(input int idx, input logic [7:0] b);
    tx_byte_a[idx] = b;
    tx_dv_a[idx]   = 1'b1;
    @(negedge clk);
    tx_dv_a[idx]   = 1'b0;
    tx_byte_a[idx] = 8'($urandom);
  endtask

  // lat counts cycles from acceptance; a timeout leaves lat beyond any legal value.
  task automatic wait_done(input int idx, output int lat);
    lat = 1;
    while (rx_dv_w[idx] !== 1'b1 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic arm_slave(input int idx, input logic [7:0] ret);
    slv_ret[idx] = ret;
    arm_req[idx] = arm_req[idx] + 1;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) begin
      tests++; if (ready_w[i] !== 1'b1) begin fails++; $display("FAIL reset_ready[%0d]: got %b expected 1", i, ready_w[i]); end
      tests++; if (rx_dv_w[i] !== 1'b0) begin fails++; $display("FAIL reset_rx_dv[%0d]: got %b expected 0", i, rx_dv_w[i]); end
      tests++; if (rx_byte_w[i] !== 8'h00) begin fails++; $display("FAIL reset_rx_byte[%0d]: got %h expected 00", i, rx_byte_w[i]); end
      tests++; if (sclk_w[i] !== cpol_of(i)) begin fails++; $display("FAIL reset_sclk[%0d]: got %b expected %b", i, sclk_w[i], cpol_of(i)); end
      tests++; if (mosi_w[i] !== 1'b0) begin fails++; $display("FAIL reset_mosi[%0d]: got %b expected 0", i, mosi_w[i]); end
    end
  endtask

  task automatic test_loopback(input int idx, input int count, input logic [7:0] first);
    logic [7:0] b;
    int lat, r0, v0;
    miso_src[idx] = 0;
    for (int k = 0; k < count; k++) begin
      b  = (k == 0) ? first : 8'($urandom);
      r0 = rises_w[idx];
      v0 = viol_w[idx];
      start_xfer(idx, b);
      wait_done(idx, lat);
      $display("[TB] loopback idx=%0d mode=%0d tx=%02h rx=%02h lat=%0d", idx, mode_of(idx), b, rx_byte_w[idx], lat);
      tests++; if (rx_byte_w[idx] !== b) begin fails++; $display("FAIL loop_rx[%0d]: got %h expected %h", idx, rx_byte_w[idx], b); end
      tests++; if (lat != 16 * chb_of(idx) + 2) begin fails++; $display("FAIL loop_latency[%0d]: got %0d expected %0d", idx, lat, 16 * chb_of(idx) + 2); end
      tests++; if (sclk_w[idx] !== cpol_of(idx)) begin fails++; $display("FAIL loop_sclk_idle[%0d]: got %b expected %b", idx, sclk_w[idx], cpol_of(idx)); end
      @(negedge clk);
      tests++; if (rises_w[idx] - r0 != 8) begin fails++; $display("FAIL loop_rises[%0d]: got %0d expected 8", idx, rises_w[idx] - r0); end
      tests++; if (rx_dv_w[idx] !== 1'b0) begin fails++; $display("FAIL loop_dv_pulse[%0d]: got %b expected 0", idx, rx_dv_w[idx]); end
      tests++; if (rx_byte_w[idx] !== b) begin fails++; $display("FAIL loop_rx_hold[%0d]: got %h expected %h", idx, rx_byte_w[idx], b); end
      if (mode_of(idx) == 0) begin
        tests++; if (viol_w[idx] != v0) begin fails++; $display("FAIL loop_mosi_stable[%0d]: got %0d changes expected 0", idx, viol_w[idx] - v0); end
      end
    end
  endtask

  task automatic test_slave_mode3();
    logic [7:0] b, ret;
    int lat;
    miso_src[1] = 1;
    for (int k = 0; k < 4; k++) begin
      b   = (k == 0) ? 8'h81 : 8'($urandom);
      ret = (k == 0) ? 8'h3C : 8'($urandom);
      arm_slave(1, ret);
      @(negedge clk);
      start_xfer(1, b);
      wait_done(1, lat);
      $display("[TB] slave idx=1 tx=%02h slave_got=%02h rx=%02h lat=%0d", b, slv_rx_w[1], rx_byte_w[1], lat);
      tests++; if (slv_rx_w[1] !== b) begin fails++; $display("FAIL m3_slave_rx: got %h expected %h", slv_rx_w[1], b); end
      tests++; if (rx_byte_w[1] !== ret) begin fails++; $display("FAIL m3_rx: got %h expected %h", rx_byte_w[1], ret); end
      tests++; if (lat != 66) begin fails++; $display("FAIL m3_latency: got %0d expected 66", lat); end
      tests++; if (sclk_w[1] !== 1'b1) begin fails++; $display("FAIL m3_sclk_idle: got %b expected 1", sclk_w[1]); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int lat, r0;
    miso_src[0] = 0;
    r0 = rises_w[0];
    start_xfer(0, 8'h12);
    wait_done(0, lat);
    $display("[TB] b2b first tx=12 rx=%02h lat=%0d", rx_byte_w[0], lat);
    tests++; if (rx_byte_w[0] !== 8'h12) begin fails++; $display("FAIL b2b_rx1: got %h expected 12", rx_byte_w[0]); end
    tests++; if (ready_w[0] !== 1'b1) begin fails++; $display("FAIL b2b_ready_done: got %b expected 1", ready_w[0]); end
    tests++; if (sclk_w[0] !== 1'b0) begin fails++; $display("FAIL b2b_sclk_between: got %b expected 0", sclk_w[0]); end
    start_xfer(0, 8'h34);
    tests++; if (ready_w[0] !== 1'b0) begin fails++; $display("FAIL b2b_accept: got ready %b expected 0", ready_w[0]); end
    tests++; if (rx_byte_w[0] !== 8'h12) begin fails++; $display("FAIL b2b_rx1_hold: got %h expected 12", rx_byte_w[0]); end
    wait_done(0, lat);
    $display("[TB] b2b second tx=34 rx=%02h lat=%0d", rx_byte_w[0], lat);
    tests++; if (rx_byte_w[0] !== 8'h34) begin fails++; $display("FAIL b2b_rx2: got %h expected 34", rx_byte_w[0]); end
    tests++; if (lat != 34) begin fails++; $display("FAIL b2b_latency2: got %0d expected 34", lat); end
    @(negedge clk);
    tests++; if (rises_w[0] - r0 != 16) begin fails++; $display("FAIL b2b_rises: got %0d expected 16", rises_w[0] - r0); end
  endtask

  task automatic test_busy_ignored();
    logic [7:0] ret;
    int lat, d0, r0;
    ret = 8'($urandom);
    miso_src[0] = 1;
    arm_slave(0, ret);
    @(negedge clk);
    d0 = dvs_w[0];
    r0 = rises_w[0];
    start_xfer(0, 8'h00);
    repeat (10) @(negedge clk);
    tests++; if (ready_w[0] !== 1'b0) begin fails++; $display("FAIL busy_ready: got %b expected 0", ready_w[0]); end
    tx_byte_a[0] = 8'hFF;
    tx_dv_a[0]   = 1'b1;
    @(negedge clk);
    tx_dv_a[0]   = 1'b0;
    wait_done(0, lat);
    repeat (40) @(negedge clk);
    $display("[TB] busy tx=00 slave_got=%02h rx=%02h", slv_rx_w[0], rx_byte_w[0]);
    tests++; if (slv_rx_w[0] !== 8'h00) begin fails++; $display("FAIL busy_slave_rx: got %h expected 00", slv_rx_w[0]); end
    tests++; if (rx_byte_w[0] !== ret) begin fails++; $display("FAIL busy_rx: got %h expected %h", rx_byte_w[0], ret); end
    tests++; if (dvs_w[0] - d0 != 1) begin fails++; $display("FAIL busy_dv_count: got %0d expected 1", dvs_w[0] - d0); end
    tests++; if (rises_w[0] - r0 != 8) begin fails++; $display("FAIL busy_rises: got %0d expected 8", rises_w[0] - r0); end
    tests++; if (ready_w[0] !== 1'b1) begin fails++; $display("FAIL busy_ready_end: got %b expected 1", ready_w[0]); end
  endtask

  task automatic test_reset_mid();
    int t0, d0, lat, guard;
    miso_src[0] = 0;
    t0 = toggles_w[0];
    start_xfer(0, 8'h77);
    guard = 0;
    while (toggles_w[0] - t0 < 5 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    tests++; if (toggles_w[0] - t0 != 5) begin fails++; $display("FAIL rst_edge_count: got %0d expected 5", toggles_w[0] - t0); end
    d0   = dvs_w[0];
    rstn = 1'b0;
    #1;
    $display("[TB] reset mid-transfer sclk=%b ready=%b", sclk_w[0], ready_w[0]);
    tests++; if (sclk_w[0] !== 1'b0) begin fails++; $display("FAIL rst_sclk: got %b expected 0", sclk_w[0]); end
    tests++; if (ready_w[0] !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b expected 1", ready_w[0]); end
    tests++; if (mosi_w[0] !== 1'b0) begin fails++; $display("FAIL rst_mosi: got %b expected 0", mosi_w[0]); end
    tests++; if (rx_byte_w[0] !== 8'h00) begin fails++; $display("FAIL rst_rx_byte: got %h expected 00", rx_byte_w[0]); end
    @(negedge clk);
    rstn = 1'b1;
    repeat (40) @(negedge clk);
    tests++; if (dvs_w[0] != d0) begin fails++; $display("FAIL rst_no_dv: got %0d pulses expected 0", dvs_w[0] - d0); end
    start_xfer(0, 8'h5A);
    wait_done(0, lat);
    $display("[TB] after reset tx=5a rx=%02h lat=%0d", rx_byte_w[0], lat);
    tests++; if (rx_byte_w[0] !== 8'h5A) begin fails++; $display("FAIL rst_resume_rx: got %h expected 5a", rx_byte_w[0]); end
    tests++; if (lat != 34) begin fails++; $display("FAIL rst_resume_latency: got %0d expected 34", lat); end
    @(negedge clk);
  endtask

  task automatic test_miso_const();
    logic [7:0] b;
    int lat;
    miso_src[2] = 2;
    for (int k = 0; k < 2; k++) begin
      miso_const[2] = (k == 0);
      b = 8'($urandom);
      start_xfer(2, b);
      wait_done(2, lat);
      $display("[TB] const idx=2 miso=%b tx=%02h rx=%02h lat=%0d", miso_const[2], b, rx_byte_w[2], lat);
      tests++; if (rx_byte_w[2] !== {8{miso_const[2]}}) begin fails++; $display("FAIL const_rx: got %h expected %h", rx_byte_w[2], {8{miso_const[2]}}); end
      tests++; if (lat != 34) begin fails++; $display("FAIL const_latency: got %0d expected 34", lat); end
      @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      tx_byte_a[i]  = 8'h00;
      tx_dv_a[i]    = 1'b0;
      miso_src[i]   = 0;
      miso_const[i] = 1'b0;
      slv_ret[i]    = 8'h00;
      arm_req[i]    = 0;
    end
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    test_loopback(0, 5, 8'hA5);
    test_slave_mode3();
    test_back_to_back();
    test_busy_ignored();
    test_reset_mid();
    test_miso_const();
    test_loopback(1, 3, 8'hC3);
    test_loopback(2, 3, 8'h3C);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
